// File: rtl/wb3_bus_master_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb3_bus_master_pkg
// Description : Shared types and default widths for the Wishbone B3 classic
//               single-transfer bus master.
// Revision    : 1.0 - initial release
// ============================================================================
package wb3_bus_master_pkg;

  // Default bus geometry, shared by the master and its benches
  localparam int C_ADDR_WIDTH = 3;
  localparam int C_DATA_WIDTH = 8;

  // Wait counter width; wide enough for the largest legal timeout (255)
  localparam int C_CNT_WIDTH  = 8;

  // Transaction FSM: accept a command, run one bus cycle, hold the response
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage : wb3_bus_master_pkg
`default_nettype wire

// File: rtl/wb3_bus_master_irq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb3_bus_master_irq
// Description : Registers the slave level interrupt and produces a one-cycle
//               pulse on its rising edge. Runs independently of the FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module wb3_bus_master_irq (
  input  logic clk,
  input  logic arst,
  input  logic inta,
  output logic irq_level,
  output logic irq_pulse
);

  logic r_level;
  logic r_pulse;

  // One register stage for the level; the pulse compares the live input
  // against the previous registered level so both outputs share the latency.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_level <= inta;
      r_pulse <= inta & ~r_level;
    end
  end

  assign irq_level = r_level;
  assign irq_pulse = r_pulse;

endmodule : wb3_bus_master_irq
`default_nettype wire

// File: rtl/wb3_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb3_bus_master
// Description : Command/response front end driving single Wishbone B3
//               classic transfers, with a no-ack timeout and an interrupt
//               level/edge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module wb3_bus_master #(
  parameter int ADDR_WIDTH     = wb3_bus_master_pkg::C_ADDR_WIDTH,
  parameter int DATA_WIDTH     = wb3_bus_master_pkg::C_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  arst,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // Wishbone B3 classic master port
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic                  wb_we_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_inta_i,
  // interrupt monitor
  output logic                  irq_level,
  output logic                  irq_pulse
);

  import wb3_bus_master_pkg::*;

  // Value of the wait counter during the last strobe cycle that may still
  // be acknowledged; without ack on that cycle the transfer is aborted.
  localparam logic [C_CNT_WIDTH-1:0] c_timeout_last =
    C_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                  r_state;
  state_e                  w_state_next;

  logic                    r_cmd_ready;
  logic                    r_rsp_valid;
  logic                    r_rsp_err;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;

  logic                    r_wb_cyc;
  logic                    r_wb_we;
  logic [ADDR_WIDTH-1:0]   r_wb_adr;
  logic [DATA_WIDTH-1:0]   r_wb_dat;

  logic [C_CNT_WIDTH-1:0]  r_wait_cnt;

  logic                    w_cmd_fire;
  logic                    w_rsp_fire;
  logic                    w_timeout;
  logic                    w_ack_done;
  logic                    w_abort_done;

  assign w_cmd_fire = cmd_valid & r_cmd_ready;
  assign w_rsp_fire = r_rsp_valid & rsp_ready;
  assign w_timeout  = (r_wait_cnt == c_timeout_last);

  // Next-state decode; ack is checked before the timeout so it wins a tie
  always_comb begin
    w_state_next = r_state;
    w_ack_done   = 1'b0;
    w_abort_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cmd_fire) begin
          w_state_next = BUS;
        end
      end
      BUS: begin
        if (wb_ack_i) begin
          w_state_next = RESP;
          w_ack_done   = 1'b1;
        end else if (w_timeout) begin
          w_state_next = RESP;
          w_abort_done = 1'b1;
        end
      end
      RESP: begin
        if (w_rsp_fire) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // cmd_ready is registered so it stays low through reset and rises on the
  // first edge after release; afterwards it tracks the IDLE state exactly.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_cmd_ready <= 1'b0;
    end else begin
      r_cmd_ready <= (w_state_next == IDLE);
    end
  end

  // Wait counter: held at zero outside BUS so each bus cycle starts from 0
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_wait_cnt <= '0;
    end else if (r_state != BUS) begin
      r_wait_cnt <= '0;
    end else if (!wb_ack_i) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Bus drivers: loaded at the command handshake, cleared when the bus
  // cycle ends so data/we read as zero whenever cyc is low.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_wb_cyc <= 1'b0;
      r_wb_we  <= 1'b0;
      r_wb_adr <= '0;
      r_wb_dat <= '0;
    end else if (w_cmd_fire) begin
      r_wb_cyc <= 1'b1;
      r_wb_we  <= cmd_we;
      r_wb_adr <= cmd_addr;
      r_wb_dat <= cmd_wdata;
    end else if (w_ack_done || w_abort_done) begin
      r_wb_cyc <= 1'b0;
      r_wb_we  <= 1'b0;
      r_wb_adr <= '0;
      r_wb_dat <= '0;
    end
  end

  // Response payload: captured when the bus cycle ends, held through RESP
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_ack_done) begin
      r_rsp_rdata <= r_wb_we ? '0 : wb_dat_i;
      r_rsp_err   <= 1'b0;
    end else if (w_abort_done) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b1;
    end
  end

  // rsp_valid rises one edge after RESP is entered and falls on handshake
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_rsp_valid <= 1'b0;
    end else if (w_rsp_fire) begin
      r_rsp_valid <= 1'b0;
    end else if (r_state == RESP) begin
      r_rsp_valid <= 1'b1;
    end
  end

  // Interrupt level/edge monitor
  wb3_bus_master_irq u_irq (
    .clk       (clk),
    .arst      (arst),
    .inta      (wb_inta_i),
    .irq_level (irq_level),
    .irq_pulse (irq_pulse)
  );

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign wb_cyc_o  = r_wb_cyc;
  assign wb_stb_o  = r_wb_cyc;
  assign wb_we_o   = r_wb_we;
  assign wb_adr_o  = r_wb_adr;
  assign wb_dat_o  = r_wb_dat;

endmodule : wb3_bus_master
`default_nettype wire

// File: tb/tb_wb3_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_wb3_bus_master
// Description : Self-checking bench for wb3_bus_master with a wait-state
//               programmable slave and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb3_bus_master;
  import wb3_bus_master_pkg::*;

  localparam int AW = C_ADDR_WIDTH;
  localparam int DW = C_DATA_WIDTH;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW-1:0] wb_dat_i = '0;
  logic          wb_we_o;
  logic          wb_stb_o;
  logic          wb_cyc_o;
  logic          wb_ack_i = 1'b0;
  logic          wb_inta_i = 1'b0;
  logic          irq_level;
  logic          irq_pulse;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb3_bus_master #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_we_o   (wb_we_o),
    .wb_stb_o  (wb_stb_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_ack_i  (wb_ack_i),
    .wb_inta_i (wb_inta_i),
    .irq_level (irq_level),
    .irq_pulse (irq_pulse)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One command through the master. The slave acks on stb cycle waits+1.
  // Reference: a transfer lasts min(waits+1, TO) strobe cycles, errors when
  // the slave would need more than TO cycles, and returns slave data only
  // for successful reads.
  task automatic run_txn(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int waits,
                         input logic [DW-1:0] sdata, input int hold);
    int            stb_cycles = 0;
    int            guard = 0;
    logic          exp_err;
    int            exp_stb;
    logic [DW-1:0] exp_rdata;
    exp_err   = (waits >= TO);
    exp_stb   = exp_err ? TO : waits + 1;
    exp_rdata = (exp_err || we) ? '0 : sdata;

    @(negedge clk);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    check("cyc_idle", 32'(wb_cyc_o), 32'd0);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_we    = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);
    while (wb_stb_o === 1'b1 && guard < 300) begin
      stb_cycles++;
      guard++;
      check("bus_cyc", 32'(wb_cyc_o), 32'd1);
      check("bus_adr", 32'(wb_adr_o), 32'(addr));
      check("bus_we", 32'(wb_we_o), 32'(we));
      check("bus_dat", 32'(wb_dat_o), 32'(wdata));
      check("bus_cmd_ready", 32'(cmd_ready), 32'd0);
      if (stb_cycles == waits + 1) begin
        wb_ack_i = 1'b1;
        wb_dat_i = sdata;
      end
      @(posedge clk);
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_dat_i = DW'($urandom);
    end
    check("stb_cycles", 32'(stb_cycles), 32'(exp_stb));
    check("cyc_dropped", 32'(wb_cyc_o), 32'd0);
    check("we_o_low", 32'(wb_we_o), 32'd0);
    check("dat_o_low", 32'(wb_dat_o), 32'd0);
    check("rsp_not_yet", 32'(rsp_valid), 32'd0);

    @(negedge clk);
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
      check("rsp_err", 32'(rsp_err), 32'(exp_err));
      check("resp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("resp_cyc", 32'(wb_cyc_o), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_consumed", 32'(rsp_valid), 32'd0);
    check("back_to_idle", 32'(cmd_ready), 32'd1);
    check("idle_cyc", 32'(wb_cyc_o), 32'd0);
  endtask

  // Global time bound
  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic drv_prev;
    logic drv_prev2;
    int   pulses;
    int   lvl_cycles;
    int   sel;
    int   waits;

    // ---- reset state ----
    #1 arst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_wb_outs", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}), 32'd0);
    check("rst_irq", 32'({irq_level, irq_pulse}), 32'd0);
    @(negedge clk);
    arst = 1'b1;
    check("rel_cmd_ready_pre", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rel_cmd_ready_post", 32'(cmd_ready), 32'd1);

    // ---- directed: write, zero wait ----
    run_txn(1'b1, 3'h2, 8'hA5, 0, 8'h77, 0);
    // ---- directed: read, 3 wait states ----
    run_txn(1'b0, 3'h4, 8'h00, 3, 8'h3C, 0);
    // ---- directed: no ack -> timeout, then a normal command ----
    run_txn(1'b0, 3'h1, 8'h5A, 40, 8'hEE, 0);
    run_txn(1'b0, 3'h6, 8'h11, 1, 8'hC3, 0);
    // ---- directed: ack on the final cycle beats the timeout ----
    run_txn(1'b0, 3'h7, 8'h22, TO - 1, 8'h9B, 0);
    // ---- directed: response back-pressure for 10 cycles ----
    run_txn(1'b0, 3'h3, 8'h44, 2, 8'hD2, 10);

    // ---- ack outside BUS is ignored ----
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wb_ack_i = 1'b1;
      wb_dat_i = 8'hFF;
      if (i > 0) begin
        check("stray_ack_cyc", 32'(wb_cyc_o), 32'd0);
        check("stray_ack_rsp", 32'(rsp_valid), 32'd0);
        check("stray_ack_ready", 32'(cmd_ready), 32'd1);
      end
    end
    @(negedge clk);
    wb_ack_i = 1'b0;

    // ---- randomized transactions ----
    for (int t = 0; t < 14; t++) begin
      sel   = int'($urandom_range(0, 7));
      waits = (sel < 5) ? sel : ((sel == 5) ? TO - 1 : ((sel == 6) ? TO : TO + 4));
      run_txn(1'($urandom), AW'($urandom), DW'($urandom), waits, DW'($urandom),
              int'($urandom_range(0, 3)));
    end

    // ---- reset during a bus cycle ----
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 3'h5;
    cmd_wdata = 8'h00;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_rst_stb_up", 32'(wb_stb_o), 32'd1);
    @(negedge clk);
    #2 arst = 1'b0;
    #1;
    check("mid_rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("mid_rst_stb", 32'(wb_stb_o), 32'd0);
    check("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd0);
    repeat (3) @(negedge clk);
    arst = 1'b1;
    check("mid_rel_ready_pre", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("mid_rel_ready_post", 32'(cmd_ready), 32'd1);
    check("mid_rel_rsp", 32'(rsp_valid), 32'd0);
    check("mid_rel_cyc", 32'(wb_cyc_o), 32'd0);
    run_txn(1'b1, 3'h0, 8'h3E, 0, 8'h00, 1);

    // ---- interrupt: input high for 5 cycles ----
    // Reference: level follows the input one edge later; pulse is high only
    // on the first of those cycles.
    drv_prev   = 1'b0;
    drv_prev2  = 1'b0;
    pulses     = 0;
    lvl_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("irq_level", 32'(irq_level), 32'(drv_prev));
        check("irq_pulse", 32'(irq_pulse), 32'(drv_prev & ~drv_prev2));
        if (irq_pulse === 1'b1) pulses++;
        if (irq_level === 1'b1) lvl_cycles++;
      end
      drv_prev2 = drv_prev;
      drv_prev  = (i >= 1 && i <= 5);
      wb_inta_i = drv_prev;
    end
    check("irq_pulse_count", 32'(pulses), 32'd1);
    check("irq_level_count", 32'(lvl_cycles), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wb3_bus_master
`default_nettype wire

// File: doc/wb3_bus_master.md
WB3_BUS_MASTER -- requirements
Module: wb3_bus_master

Interface
REQ-001 The block SHALL take one clock and an asynchronous active-low reset: clk, arst.
REQ-002 Parameters SHALL be (name, default, meaning):
- ADDR_WIDTH, 3, Wishbone address width.
- DATA_WIDTH, 8, Wishbone data width.
- TIMEOUT_CYCLES, 16, maximum cycles stb is held without ack before abort; legal range 1..255.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  system clock, all logic on rising edge.
- arst  in  1  asynchronous reset, active low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target register address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors).
- rsp_err  out  1  transaction aborted by timeout.
- wb_adr_o  out  ADDR_WIDTH  drives slave addr.
- wb_dat_o  out  DATA_WIDTH  drives slave dat_i.
- wb_dat_i  in  DATA_WIDTH  from slave dat_o.
- wb_we_o, wb_stb_o, wb_cyc_o  out  1 each  Wishbone B3 classic controls.
- wb_ack_i  in  1  slave acknowledge.
- wb_inta_i  in  1  slave interrupt, level.
- irq_level  out  1  registered copy of wb_inta_i.
- irq_pulse  out  1  one-cycle pulse on the rising edge of wb_inta_i.

Function
REQ-004 The FSM SHALL have states IDLE, BUS and RESP.
REQ-005 cmd_ready SHALL be high only in IDLE; a handshake in IDLE SHALL latch we/addr/wdata and move to BUS.
REQ-006 In BUS, wb_cyc_o and wb_stb_o SHALL be 1, starting the cycle after the handshake, with wb_adr_o, wb_we_o and wb_dat_o stable from latched values.
REQ-007 In BUS, wb_ack_i sampled high SHALL:
- capture wb_dat_i into rsp_rdata on reads (0 on writes),
- clear rsp_err,
- drop cyc/stb on the next cycle,
- enter RESP.
REQ-008 Minimum command-to-response latency SHALL be 2 cycles: handshake at edge N, stb visible N+1, ack at edge N+1, rsp_valid high after edge N+2.
REQ-009 A wait counter SHALL clear on entry to BUS and increment each BUS cycle without ack; reaching TIMEOUT_CYCLES without ack SHALL drop cyc/stb and enter RESP with rsp_err=1 and rsp_rdata=0.
REQ-010 If ack and the timeout coincide on the same cycle, ack SHALL win (rsp_err=0).
REQ-011 In RESP, rsp_valid SHALL be 1 with data held stable until rsp_ready; that handshake SHALL return to IDLE.
REQ-012 Back-to-back commands SHALL be separated by at least one IDLE cycle, with cyc low for at least one cycle between bus cycles.
REQ-013 wb_ack_i outside BUS SHALL be ignored.
REQ-014 wb_dat_o and wb_we_o SHALL be 0 when cyc is low.
REQ-015 irq_level and irq_pulse SHALL be registered (1-cycle latency) and independent of the FSM.

Reset
REQ-016 Assertion of arst SHALL asynchronously force:
- state IDLE,
- outputs cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, all wb_*_o=0, irq_level=0, irq_pulse=0,
- counter cleared.
REQ-017 cmd_ready SHALL rise on the first clk edge after arst deasserts.
REQ-018 Reset mid-BUS SHALL drop cyc/stb immediately, with no response generated.

Structure
REQ-019 A shared package SHALL hold the state enum (IDLE/BUS/RESP) and the default ADDR_WIDTH/DATA_WIDTH constants matching the testbench defines.
REQ-020 No sub-module is required; the interrupt edge detector MAY be inline logic.

Verification
REQ-021 Write: cmd addr=3'h2, wdata=8'hA5, slave ack on the first stb cycle -> one bus cycle with adr=2, we=1, dat_o=A5; rsp_valid after 2 cycles, rsp_err=0.
REQ-022 Read with 3 wait states: addr=3'h4, slave returns 8'h3C -> stb held 4 cycles, rsp_rdata=3C, rsp_err=0.
REQ-023 No ack with TIMEOUT_CYCLES=16 -> stb drops after 16 cycles, rsp_err=1, rsp_rdata=0; next command proceeds normally.
REQ-024 rsp_ready held low 10 cycles -> rsp_valid and data stable, cmd_ready=0, no new bus cycle.
REQ-025 arst asserted during BUS -> cyc/stb low asynchronously, no rsp_valid, cmd_ready=1 one edge after release.
REQ-026 wb_inta_i 0->1 held 5 cycles -> irq_pulse high exactly 1 cycle, irq_level high 5 cycles, 1-cycle delayed.
